// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side slice: FIFO geometry constants,
// the drain controller state encoding and a small index-width helper.
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PTR_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } drain_state_t;

  // Width of an index into an n-entry array, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Skid queue for fifo_drain_ctrl: SKID_DEPTH-entry circular buffer with
// head/tail pointers and an occupancy count. Callers never push when full or
// pop when empty; the top's read-issue rule guarantees that.
module drain_skid_buf #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [DATA_W-1:0]                 push_data,
  input  logic                              pop,
  output logic [DATA_W-1:0]                 head_data,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   count
);

  import fifo_pkg::*;

  localparam int unsigned IDX_W = idx_w(SKID_DEPTH);
  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SKID_DEPTH - 1);

  logic [DATA_W-1:0] mem [SKID_DEPTH];
  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;

  // Pointer advance with wrap at SKID_DEPTH, valid for non-power-of-two depths.
  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] p);
    return (p == LAST) ? '0 : p + IDX_W'(1);
  endfunction

  // Storage: write the pushed word at the tail slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[tail] <= push_data;
    end
  end

  // Pointers: tail moves on push, head moves on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) begin
        tail <= nxt(tail);
      end
      if (pop) begin
        head <= nxt(head);
      end
    end
  end

  // Occupancy: simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for the 16x8 FIFO. Issues the active-low read strobe
// while the FIFO has data and the skid buffer can absorb the one-cycle read
// latency, then presents words on a valid/ready stream.
// Optional build macro: DRAIN_STATS_EN adds stats_clr, word_cnt and uf_cnt.
module fifo_drain_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic              fifo_under_flow,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_n,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy
`ifdef DRAIN_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       word_cnt,
  output logic [7:0]        uf_cnt
`endif
);

  import fifo_pkg::*;

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  drain_state_t       state;
  logic               inflight;
  logic [CNT_W-1:0]   buf_cnt;
  logic               pop;
  logic               push;
  logic               rd;
  logic [OCC_W-1:0]   occ_next;

  assign m_valid   = (buf_cnt != '0);
  assign pop       = m_valid & m_ready;
  assign push      = inflight & ~fifo_under_flow;
  assign fifo_rd_n = ~rd;

  // Read issue: only in RUN, FIFO non-empty, and a slot stays free for the
  // returning word after this cycle's pop (m_ready feeds this path directly).
  always_comb begin
    occ_next = OCC_W'(buf_cnt) + OCC_W'(inflight) - OCC_W'(pop);
    rd       = (state == RUN) && !fifo_empty && (occ_next < OCC_W'(SKID_DEPTH));
  end

  // In-flight flag: the FIFO returns data the cycle after a strobed read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd;
    end
  end

  // Control FSM; busy is updated on the same edges as state so it stays a
  // flop output equal to (state != IDLE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (en) begin
            state <= RUN;
          end else if (!inflight && buf_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  drain_skid_buf #(
    .DATA_W     (DATA_W),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_data),
    .pop       (pop),
    .head_data (m_data),
    .count     (buf_cnt)
  );

`ifdef DRAIN_STATS_EN
  // Handshake counter, wraps at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (stats_clr) begin
      word_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

  // Discarded-capture counter, saturates at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uf_cnt <= '0;
    end else if (stats_clr) begin
      uf_cnt <= '0;
    end else if (inflight && fifo_under_flow && uf_cnt != '1) begin
      uf_cnt <= uf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural FIFO source model.
module tb_fifo_drain_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       m_ready = 1'b0;
  logic       fifo_empty;
  logic       fifo_under_flow = 1'b0;
  logic [7:0] fifo_data = '0;
  logic       fifo_rd_n;
  logic       m_valid;
  logic [7:0] m_data;
  logic       busy;
`ifdef DRAIN_STATS_EN
  logic       stats_clr = 1'b0;
  logic [15:0] word_cnt;
  logic [7:0] uf_cnt;
`endif

  // FIFO model controls
  int unsigned avail = 0;
  logic [7:0]  nv = 8'h01;
  logic        ld_req = 1'b0;
  int unsigned ld_n = 0;
  logic        lie = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(
    .DATA_W     (8),
    .SKID_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .fifo_empty      (fifo_empty),
    .fifo_under_flow (fifo_under_flow),
    .fifo_data       (fifo_data),
    .fifo_rd_n       (fifo_rd_n),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .busy            (busy)
`ifdef DRAIN_STATS_EN
    ,
    .stats_clr       (stats_clr),
    .word_cnt        (word_cnt),
    .uf_cnt          (uf_cnt)
`endif
  );

  // Source FIFO: words 1,2,3,... with one-cycle read latency; a read while
  // empty flags underflow on the following cycle. It ignores rst.
  assign fifo_empty = (avail == 0) && !lie;

  always @(posedge clk) begin
    if (ld_req) begin
      avail           <= ld_n;
      nv              <= 8'h01;
      fifo_under_flow <= 1'b0;
    end else if (!fifo_rd_n) begin
      if (avail != 0) begin
        fifo_data       <= nv;
        nv              <= nv + 8'h01;
        avail           <= avail - 1;
        fifo_under_flow <= 1'b0;
      end else begin
        fifo_under_flow <= 1'b1;
      end
    end else begin
      fifo_under_flow <= 1'b0;
    end
  end

  typedef struct {
    int unsigned load_n;
    logic        en;
    logic        rdy;
    logic        rd_n;
    logic        vld;
    logic [7:0]  dat;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int unsigned l, input logic e, input logic r,
                              input logic rdn, input logic v, input logic [7:0] d,
                              input logic b);
    vec_t t;
    t.load_n = l; t.en = e; t.rdy = r; t.rd_n = rdn; t.vld = v; t.dat = d; t.bsy = b;
    vecs.push_back(t);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, settle, then sample.
  task automatic cyc(input int unsigned l, input logic e, input logic r, input logic lz);
    @(negedge clk);
    ld_n   = l;
    ld_req = (l != 0);
    en     = e;
    m_ready = r;
    lie    = lz;
    #1;
  endtask

  int hs;
  int rds;
  logic [7:0] exp_d;

  initial begin
    // --- Table: full-rate burst of 5 ---
    add(5,0,1, 1,0,8'h00,0);
    add(0,1,1, 1,0,8'h00,0);
    add(0,1,1, 0,0,8'h00,1);
    add(0,1,1, 0,0,8'h00,1);
    add(0,1,1, 0,1,8'h01,1);
    add(0,1,1, 0,1,8'h02,1);
    add(0,1,1, 0,1,8'h03,1);
    add(0,1,1, 1,1,8'h04,1);
    add(0,1,1, 1,1,8'h05,1);
    add(0,1,1, 1,0,8'h00,1);
    add(0,0,1, 1,0,8'h00,1);
    add(0,0,1, 1,0,8'h00,1);
    add(0,0,1, 1,0,8'h00,0);
    // --- Table: back-pressure, buffer fills with 2, then releases ---
    add(5,0,0, 1,0,8'h00,0);
    add(0,1,0, 1,0,8'h00,0);
    add(0,1,0, 0,0,8'h00,1);
    add(0,1,0, 0,0,8'h00,1);
    add(0,1,0, 1,1,8'h01,1);
    add(0,1,0, 1,1,8'h01,1);
    add(0,1,0, 1,1,8'h01,1);
    add(0,1,0, 1,1,8'h01,1);
    add(0,1,1, 0,1,8'h01,1);
    add(0,1,1, 0,1,8'h02,1);
    add(0,1,1, 0,1,8'h03,1);
    add(0,1,1, 1,1,8'h04,1);
    add(0,1,1, 1,1,8'h05,1);
    add(0,1,1, 1,0,8'h00,1);
    add(0,0,1, 1,0,8'h00,1);
    add(0,0,1, 1,0,8'h00,1);
    add(0,0,1, 1,0,8'h00,0);
    // --- Table: en dropped with one word buffered and one in flight ---
    add(5,0,0, 1,0,8'h00,0);
    add(0,1,0, 1,0,8'h00,0);
    add(0,1,0, 0,0,8'h00,1);
    add(0,1,0, 0,0,8'h00,1);
    add(0,0,0, 1,1,8'h01,1);
    add(0,0,0, 1,1,8'h01,1);
    add(0,0,1, 1,1,8'h01,1);
    add(0,0,1, 1,1,8'h02,1);
    add(0,0,1, 1,0,8'h00,1);
    add(0,0,1, 1,0,8'h00,0);

    // Reset state
    #1;
    check("reset rd_n", 32'(fifo_rd_n), 32'd1);
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset m_data", 32'(m_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].load_n, vecs[i].en, vecs[i].rdy, 1'b0);
      check($sformatf("vec%0d rd_n", i), 32'(fifo_rd_n), 32'(vecs[i].rd_n));
      check($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vecs[i].vld));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
      if (vecs[i].vld) begin
        check($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vecs[i].dat));
      end
    end

    // --- Reset mid-burst with two words buffered ---
    cyc(5, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    check("midrst pre m_valid", 32'(m_valid), 32'd1);
    check("midrst pre rd_n", 32'(fifo_rd_n), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst rd_n", 32'(fifo_rd_n), 32'd1);
    check("midrst m_valid", 32'(m_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    rds = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0);
      if (!fifo_rd_n) rds++;
    end
    check("postrst no reads", 32'(rds), 32'd0);
    hs = 0;
    exp_d = 8'h03;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0);
      if (m_valid && m_ready) begin
        check($sformatf("postrst data%0d", hs), 32'(m_data), 32'(exp_d));
        exp_d = exp_d + 8'h01;
        hs++;
      end
    end
    check("postrst words", 32'(hs), 32'd3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    check("postrst idle busy", 32'(busy), 32'd0);

    // --- Lagging empty flag: second read underflows and is discarded ---
    cyc(1, 0, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    check("uf first read", 32'(fifo_rd_n), 32'd0);
    cyc(0, 1, 1, 1);
    check("uf second read", 32'(fifo_rd_n), 32'd0);
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 1, 0);
      if (m_valid && m_ready) begin
        check("uf data", 32'(m_data), 32'h01);
        hs++;
      end
    end
    check("uf words", 32'(hs), 32'd1);
`ifdef DRAIN_STATS_EN
    check("uf_cnt", 32'(uf_cnt), 32'd1);
`endif
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    check("uf idle busy", 32'(busy), 32'd0);

    // --- 300-word stream at full rate ---
`ifdef DRAIN_STATS_EN
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
`endif
    cyc(300, 0, 1, 0);
    hs = 0;
    exp_d = 8'h01;
    for (int i = 0; i < 305; i++) begin
      cyc(0, 1, 1, 0);
      if (m_valid && m_ready) begin
        if (m_data !== exp_d) check($sformatf("stream data%0d", hs), 32'(m_data), 32'(exp_d));
        exp_d = exp_d + 8'h01;
        hs++;
      end
    end
    check("stream words", 32'(hs), 32'd300);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    check("stream idle busy", 32'(busy), 32'd0);
`ifdef DRAIN_STATS_EN
    check("word_cnt before clr", 32'(word_cnt), 32'd300);
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1;
    check("word_cnt after clr", 32'(word_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Read-side controller placed directly downstream of the 16-deep, 8-bit FIFO. Issues the FIFO's active-low read strobe while the FIFO reports data. Absorbs the FIFO's one-cycle read latency in a small skid buffer and presents the words on a valid/ready stream to the consumer. Sustains one word per cycle and never loses a word to back-pressure.

## Interface
- DATA_W, 8, word width; matches FIFO data width
- SKID_DEPTH, 2, skid buffer entries; minimum 2 for full throughput
- clk  input  1  rising-edge clock shared with the FIFO
- rst  input  1  asynchronous, active-high reset
- en  input  1  level; 1 = drain FIFO, 0 = stop issuing reads
- fifo_empty  input  1  FIFO empty flag
- fifo_under_flow  input  1  FIFO underflow flag
- fifo_data  input  DATA_W  FIFO read data; valid one cycle after rd_n low
- fifo_rd_n  output  1  FIFO read strobe, active low
- m_valid  output  1  stream word valid
- m_ready  input  1  consumer accepts word
- m_data  output  DATA_W  stream word
- busy  output  1  high whenever state is not IDLE

## Operation
- Skid buffer: SKID_DEPTH-entry circular queue with head/tail pointers and buffer count buf_cnt. m_valid = (buf_cnt != 0). m_data = entry at head.
- In-flight tracking: a 1-bit register inflight is set to 1 in the cycle after fifo_rd_n is low.
- Read issue: fifo_rd_n = 0 iff state == RUN, fifo_empty == 0, and (buf_cnt + inflight − pop) < SKID_DEPTH, where pop = m_valid & m_ready. The resulting combinational path m_ready -> fifo_rd_n is intended.
- Capture: in a cycle with inflight == 1:
  - if fifo_under_flow == 0, push fifo_data at the tail.
  - if fifo_under_flow == 1, discard it. This covers the FIFO's lagging empty flag.
- Push and pop in the same cycle leave buf_cnt unchanged. Both pointers wrap modulo SKID_DEPTH.
- FSM states:
  - IDLE: no reads.
    - en = 1 -> RUN.
  - RUN: reads issued per the rule above.
    - en = 0 -> DRAIN.
  - DRAIN: no new reads; the in-flight word is captured and the buffer is delivered.
    - inflight == 0 and buf_cnt == 0 -> IDLE.
    - en = 1 -> RUN.
- Boundaries:
  - Buffer full with m_ready = 0: no read is issued. The in-flight word always has a free slot by construction.
  - fifo_empty = 1 in RUN: no read. The FSM stays in RUN.
  - Reset mid-operation: buffer contents and the in-flight word are lost. The FIFO keeps its own state.

## Timing
- Reset values:
  - fifo_rd_n = 1, m_valid = 0, m_data = 0, busy = 0
  - state = IDLE, buf_cnt = 0, inflight = 0, pointers = 0
- Read at edge t: fifo_data is captured at edge t+1. m_valid rises after edge t+1 at the earliest, so latency from read to m_valid is 1 cycle.
- Steady state with m_ready held high and FIFO non-empty: one read per cycle, one word out per cycle.
- m_data and m_valid are stable while m_valid = 1 and m_ready = 0.

## Configuration
- DRAIN_STATS_EN defined: adds the following ports:
  - stats_clr input 1: synchronous clear of both counters.
  - word_cnt output 16: wrapping count of stream handshakes (pop).
  - uf_cnt output 8: saturating count of discarded captures, holding at 255.
  - Both counters reset to 0.
- DRAIN_STATS_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package fifo_pkg holds:
  - constants FIFO_DEPTH = 16, DATA_W = 8, PTR_W = 4
  - enum drain_state_t {IDLE, RUN, DRAIN}
- One sub-module, drain_skid_buf: the SKID_DEPTH queue with push/pop/count. FSM, read-issue and stats logic stay in the top.

## Test plan
- Reset asserted mid-burst with buf_cnt = 2 -> immediately fifo_rd_n = 1, m_valid = 0, busy = 0. After release there are no reads until en = 1.
- FIFO preloaded 0x01..0x05, en = 1, m_ready = 1 -> reads on 5 consecutive cycles. m_data is 0x01..0x05 on consecutive cycles starting 1 cycle after the first read.
- Same preload, m_ready = 0 for 6 cycles -> exactly 2 reads issued and buf_cnt = 2, with m_data = 0x01 held. Then m_ready = 1 -> 0x01..0x05 in order, no loss.
- FIFO has 1 word and fifo_under_flow is forced high on the capture cycle of a second read -> only one word is delivered. uf_cnt = 1 with DRAIN_STATS_EN.
- en dropped while a read is in flight and 1 word is buffered -> state is DRAIN, no further reads, both words delivered, then IDLE with busy = 0.
- DRAIN_STATS_EN: 300 handshakes then stats_clr -> word_cnt = 300 before the clear, 0 the cycle after.
